phase_shift_divider: RTL and testbench
======================================

# phase_shift_divider

Programmable clock-enable divider for the DPLL loop: divides `clk_i` by a runtime divisor and produces a square wave plus a period-start tick. It accepts phase-advance and phase-retard requests from the phase detector, accumulates them in a saturating signed counter, and applies at most one request per output period by shortening or lengthening that period by one clock. It sits between the phase detector/loop filter and the recovered-clock consumers.

## Interface
- `WIDTH`, 8, width of `divisor_i`; internal period counter is WIDTH+1 bits.
- `PEND_WIDTH`, 4, width of the signed pending-shift accumulator; range ±(2^(PEND_WIDTH-1)-1).
- `clk_i`  in  1  system clock; all state changes on its rising edge.
- `reset_i`  in  1  asynchronous, active-low reset.
- `enable_i`  in  1  count enable; low freezes all state.
- `divisor_i`  in  WIDTH  nominal period N in clocks; values 0..2 are treated as 3.
- `positiveShift_i`  in  1  one-cycle request: advance phase by one clock.
- `negativeShift_i`  in  1  one-cycle request: retard phase by one clock.
- `output_o`  out  1  divided square wave.
- `tick_o`  out  1  one-cycle pulse on the first cycle of each period.
- `pending_o`  out  PEND_WIDTH  signed net pending shifts (positive = advances owed).
- `overflow_o`  out  1  one-cycle pulse when a request is dropped by saturation.

## Operation
- State: counter `cnt` (0..P-1), current period length `P`, `started` flag, pending accumulator `pend`.
- Period start occurs on an enabled edge when `started`=0 or `cnt`=P-1. On that edge:
  - Nc = max(divisor_i, 3), sampled on this edge only.
  - adj = -1 if pend>0, +1 if pend<0, else 0. P <= Nc+adj (range 2..2^WIDTH), `cnt` <= 0, `started` <= 1.
  - tick_o <= 1, output_o <= 1.
- Other enabled edges: `cnt` <= cnt+1; tick_o <= 0; output_o <= 1 if (cnt+1) < (P>>1), else 0. High time = floor(P/2), low time = ceil(P/2).
- Pending update on every enabled edge: consume = -adj at period start, else 0; delta = positiveShift_i - negativeShift_i (both high = 0). Candidate = pend - consume + delta. If |candidate| exceeds 2^(PEND_WIDTH-1)-1, the request is dropped (pend <= pend - consume), and overflow_o pulses for one cycle.
- adj uses the registered `pend` value from before the edge; a request sampled on a period-start edge takes effect at the next period start at the earliest.
- Only one adjustment is applied per period; excess requests remain queued in `pend`.
- When enable_i is low, `cnt`, P, pend, `started` and output_o hold; tick_o and overflow_o are 0 on the following edge; shift requests are ignored.
- Reset (async, any time): cnt=0, P=0, started=0, pend=0, output_o=0, tick_o=0, overflow_o=0, pending_o=0. This takes effect immediately, mid-period included.

## Timing
- First enabled edge after reset release: tick_o=1, output_o=1 (latency 1 clock).
- tick_o spacing equals the P of the period it opens; a divisor change becomes visible only at the next tick.
- pending_o reflects a request 1 clock after the sampling edge.
- overflow_o is asserted on the cycle after the dropped request's edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, divisor_i=8, enable_i=1 -> tick every 8 clocks from the first edge, output_o 4 high / 4 low, pending_o=0.
- One positiveShift_i pulse mid-period -> pending_o=1 next clock; next period 7 clocks, then 8 again; pending_o returns to 0 at that tick. Same with negativeShift_i -> one 9-clock period.
- Three positiveShift_i pulses in one period -> pending_o=3, then three consecutive 7-clock periods. Both shift inputs high together -> pending_o unchanged, periods stay 8.
- PEND_WIDTH=4, divisor_i=200, 8 positiveShift_i pulses in consecutive cycles -> pending_o saturates at 7, overflow_o pulses once after the 8th. Separately, divisor_i=1 plus one advance -> a 2-clock period (1 high / 1 low), then 3-clock periods.
- divisor_i changed 8→5 mid-period -> current period completes at 8, following periods are 5 (2 high / 3 low). enable_i low for 3 clocks mid-period -> that period is stretched by exactly 3 clocks, with no tick while disabled.
- reset_i asserted mid-period with pending_o=2 -> all outputs go to 0 immediately. After release, the first enabled edge gives a tick with an unshifted period.

Source files
------------

// File: rtl/phase_shift_divider.sv
// Programmable clock-enable divider with phase advance/retard.
// Shift requests queue in a saturating signed counter; at most one is applied per output period.
module phase_shift_divider #(
  parameter int WIDTH      = 8,
  parameter int PEND_WIDTH = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         enable_i,
  input  logic [WIDTH-1:0]             divisor_i,
  input  logic                         positiveShift_i,
  input  logic                         negativeShift_i,
  output logic                         output_o,
  output logic                         tick_o,
  output logic signed [PEND_WIDTH-1:0] pending_o,
  output logic                         overflow_o
);

  localparam int CW = WIDTH + 1;
  localparam int AW = PEND_WIDTH + 1;
  localparam logic signed [AW-1:0] PEND_MAX = AW'((1 << (PEND_WIDTH - 1)) - 1);
  localparam logic signed [AW-1:0] PEND_MIN = -PEND_MAX;

  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [CW-1:0]                 per_q, per_d;
  logic                          started_q, started_d;
  logic signed [PEND_WIDTH-1:0]  pend_q, pend_d;
  logic                          out_q, out_d;
  logic                          tick_q, tick_d;
  logic                          ovf_q, ovf_d;

  logic                          period_start;
  logic                          shorten;
  logic                          lengthen;
  logic [CW-1:0]                 nominal;
  logic signed [AW-1:0]          pend_base;
  logic signed [AW-1:0]          delta;
  logic signed [AW-1:0]          candidate;
  logic                          saturate;

  // A period opens on the very first enabled edge and whenever the last count is reached.
  always_comb begin
    period_start = enable_i && (!started_q || (cnt_q == per_q - CW'(1)));
    nominal      = (divisor_i < WIDTH'(3)) ? CW'(3) : {1'b0, divisor_i};
    lengthen     = pend_q[PEND_WIDTH-1];
    shorten      = !pend_q[PEND_WIDTH-1] && (pend_q != '0);
  end

  // Pending accumulator: consume one owed shift at period start, then add the new request.
  always_comb begin
    pend_base = {pend_q[PEND_WIDTH-1], pend_q};
    if (period_start && shorten) begin
      pend_base = pend_base - AW'(1);
    end else if (period_start && lengthen) begin
      pend_base = pend_base + AW'(1);
    end

    delta = '0;
    if (positiveShift_i && !negativeShift_i) begin
      delta = AW'(1);
    end else if (negativeShift_i && !positiveShift_i) begin
      delta = AW'(-1);
    end

    candidate = pend_base + delta;
    saturate  = (candidate > PEND_MAX) || (candidate < PEND_MIN);
  end

  // NOTE: every signal gets a hold/default value first so no path can infer a latch.
  always_comb begin
    cnt_d     = cnt_q;
    per_d     = per_q;
    started_d = started_q;
    pend_d    = pend_q;
    out_d     = out_q;
    tick_d    = 1'b0;
    ovf_d     = 1'b0;

    if (enable_i) begin
      if (period_start) begin
        cnt_d     = '0;
        per_d     = nominal - CW'(shorten) + CW'(lengthen);
        started_d = 1'b1;
        tick_d    = 1'b1;
        out_d     = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
        out_d = (cnt_q + CW'(1)) < (per_q >> 1);
      end

      if (saturate) begin
        pend_d = pend_base[PEND_WIDTH-1:0];
        ovf_d  = 1'b1;
      end else begin
        pend_d = candidate[PEND_WIDTH-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: every flop here is real control state, so all of them take the async reset.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q     <= '0;
      per_q     <= '0;
      started_q <= 1'b0;
      pend_q    <= '0;
      out_q     <= 1'b0;
      tick_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      started_q <= started_d;
      pend_q    <= pend_d;
      out_q     <= out_d;
      tick_q    <= tick_d;
      ovf_q     <= ovf_d;
    end
  end

  assign output_o   = out_q;
  assign tick_o     = tick_q;
  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_phase_shift_divider.sv
// Scoreboard bench for phase_shift_divider: a phase-index reference model predicts each cycle's
// outputs, a monitor compares them, and directed scenarios check tick spacing against fixed values.
module tb_phase_shift_divider;

  localparam int WIDTH      = 8;
  localparam int PEND_WIDTH = 4;
  localparam int PEND_LIM   = (1 << (PEND_WIDTH - 1)) - 1;

  logic                         clk_i = 1'b0;
  logic                         reset_i;
  logic                         enable_i;
  logic [WIDTH-1:0]             divisor_i;
  logic                         positiveShift_i;
  logic                         negativeShift_i;
  logic                         output_o;
  logic                         tick_o;
  logic signed [PEND_WIDTH-1:0] pending_o;
  logic                         overflow_o;

  phase_shift_divider #(.WIDTH(WIDTH), .PEND_WIDTH(PEND_WIDTH)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .enable_i        (enable_i),
    .divisor_i       (divisor_i),
    .positiveShift_i (positiveShift_i),
    .negativeShift_i (negativeShift_i),
    .output_o        (output_o),
    .tick_o          (tick_o),
    .pending_o       (pending_o),
    .overflow_o      (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit tick;
    bit out;
    int pend;
    bit ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: position k within a period of length P, plus integer pending count.
  bit m_started;
  int m_k;
  int m_p;
  int m_pend;
  bit m_out;

  // Observed statistics gathered by the monitor.
  int ivals[$];
  int ovf_cnt;
  int max_pend;
  int cyc;
  int last_tick;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int count_val(input int v);
    int n = 0;
    foreach (ivals[i]) if (ivals[i] == v) n++;
    return n;
  endfunction

  function automatic int count_other(input int a, input int b);
    int n = 0;
    foreach (ivals[i]) if (ivals[i] != a && ivals[i] != b) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_started = 0;
    m_k       = 0;
    m_p       = 0;
    m_pend    = 0;
    m_out     = 0;
  endtask

  task automatic model_step(input bit en, input int div, input bit ps, input bit ns, output exp_t e);
    bit start;
    int adj;
    int base;
    int cand;
    e.tick = 0;
    e.ovf  = 0;
    if (en) begin
      start = !m_started || (m_k == m_p - 1);
      adj   = 0;
      if (start) begin
        if (m_pend > 0) adj = -1;
        else if (m_pend < 0) adj = 1;
        m_p       = ((div < 3) ? 3 : div) + adj;
        m_k       = 0;
        m_started = 1;
      end else begin
        m_k++;
      end
      m_out  = (m_k < m_p / 2);
      e.tick = start;
      base   = m_pend + adj;
      cand   = base + int'(ps) - int'(ns);
      if (cand > PEND_LIM || cand < -PEND_LIM) begin
        m_pend = base;
        e.ovf  = 1;
      end else begin
        m_pend = cand;
      end
    end
    e.out  = m_out;
    e.pend = m_pend;
  endtask

  // Assumes the caller is at a falling edge; drives one cycle and returns at the next one.
  task automatic cycle(input bit en, input bit ps, input bit ns);
    exp_t e;
    enable_i        = en;
    positiveShift_i = ps;
    negativeShift_i = ns;
    model_step(en, int'(divisor_i), ps, ns, e);
    sb_q.push_back(e);
    @(negedge clk_i);
  endtask

  task automatic run(input int n);
    repeat (n) cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic clear_stats();
    ivals.delete();
    ovf_cnt  = 0;
    max_pend = 0;
  endtask

  // Asserts reset between edges, checks outputs clear at once, then releases with a new divisor.
  task automatic do_reset(input int div);
    reset_i = 1'b0;
    #1;
    check("rst_output",   int'(output_o),   0);
    check("rst_tick",     int'(tick_o),     0);
    check("rst_pending",  int'($signed(pending_o)), 0);
    check("rst_overflow", int'(overflow_o), 0);
    model_reset();
    sb_q.delete();
    divisor_i = WIDTH'(div);
    @(negedge clk_i);
    @(negedge clk_i);
    clear_stats();
    reset_i = 1'b1;
  endtask

  // Monitor: pops one expectation per enabled-or-not clock while out of reset.
  initial begin
    exp_t e;
    cyc       = 0;
    last_tick = -1;
    forever begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (!reset_i) begin
        last_tick = -1;
      end else if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("tick@%0d", cyc),     int'(tick_o),               int'(e.tick));
        check($sformatf("output@%0d", cyc),   int'(output_o),             int'(e.out));
        check($sformatf("pending@%0d", cyc),  int'($signed(pending_o)),   e.pend);
        check($sformatf("overflow@%0d", cyc), int'(overflow_o),           int'(e.ovf));
        if (tick_o) begin
          if (last_tick >= 0) ivals.push_back(cyc - last_tick);
          last_tick = cyc;
        end
        if (overflow_o) ovf_cnt++;
        if (int'($signed(pending_o)) > max_pend) max_pend = int'($signed(pending_o));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i         = 1'b0;
    enable_i        = 1'b0;
    divisor_i       = 8'd8;
    positiveShift_i = 1'b0;
    negativeShift_i = 1'b0;
    model_reset();
    clear_stats();
    @(negedge clk_i);
    do_reset(8);

    // Nominal divide-by-8.
    run(41);
    check("div8_count", count_val(8) >= 4 ? 1 : 0, 1);
    check("div8_other", count_other(8, 8), 0);

    // Single advance -> one 7-clock period.
    do_reset(8);
    run(3);
    cycle(1'b1, 1'b1, 1'b0);
    check("adv_pending", int'($signed(pending_o)), 1);
    run(30);
    check("adv_p7", count_val(7), 1);
    check("adv_other", count_other(7, 8), 0);

    // Single retard -> one 9-clock period.
    do_reset(8);
    run(3);
    cycle(1'b1, 1'b0, 1'b1);
    check("ret_pending", int'($signed(pending_o)), -1);
    run(30);
    check("ret_p9", count_val(9), 1);
    check("ret_other", count_other(8, 9), 0);

    // Three advances in one period -> three consecutive 7-clock periods.
    do_reset(8);
    run(2);
    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    check("adv3_pending", int'($signed(pending_o)), 3);
    run(40);
    check("adv3_p7", count_val(7), 3);
    check("adv3_other", count_other(7, 8), 0);

    // Both requests together cancel.
    do_reset(8);
    run(2);
    cycle(1'b1, 1'b1, 1'b1);
    check("both_pending", int'($signed(pending_o)), 0);
    run(30);
    check("both_other", count_other(8, 8), 0);

    // Saturation at +7 with a single overflow pulse.
    do_reset(200);
    run(10);
    repeat (8) cycle(1'b1, 1'b1, 1'b0);
    run(3);
    check("sat_max", max_pend, PEND_LIM);
    check("sat_ovf_pulses", ovf_cnt, 1);

    // Divisor below 3 plus one advance -> a 2-clock period among 3-clock ones.
    do_reset(1);
    run(4);
    cycle(1'b1, 1'b1, 1'b0);
    run(20);
    check("min_p2", count_val(2), 1);
    check("min_other", count_other(2, 3), 0);

    // Divisor change takes effect only at the next period start.
    do_reset(8);
    run(12);
    divisor_i = 8'd5;
    run(30);
    check("chg_p8", count_val(8), 2);
    check("chg_p5", count_val(5) >= 4 ? 1 : 0, 1);
    check("chg_other", count_other(5, 8), 0);

    // Enable low for 3 clocks stretches one period to 11.
    divisor_i = 8'd8;
    do_reset(8);
    run(3);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    run(30);
    check("en_p11", count_val(11), 1);
    check("en_other", count_other(8, 11), 0);

    // Reset mid-period with two advances owed; the next period is unshifted.
    do_reset(200);
    run(5);
    repeat (2) cycle(1'b1, 1'b1, 1'b0);
    run(5);
    check("pre_rst_pending", int'($signed(pending_o)), 2);
    do_reset(8);
    run(20);
    check("post_rst_p8", count_val(8) >= 2 ? 1 : 0, 1);
    check("post_rst_other", count_other(8, 8), 0);

    // Randomized traffic, including divisors 0..2 and disabled cycles.
    do_reset(int'($urandom_range(0, 12)));
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) divisor_i = WIDTH'($urandom_range(0, 12));
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    end

    run(2);
    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
